// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared definitions for the APB command master and its
// downstream memory slave.
//   - apb_state_t  : 2-bit FSM encoding IDLE/SETUP/ACCESS/RESP
//   - APB_ADDR_W   : default address width (32-entry slave memory)
//   - APB_DATA_W   : default data width
package apb_master_pkg;

  localparam int APB_ADDR_W = 5;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

endpackage

// File: rtl/apb_timeout_ctr.sv
// apb_timeout_ctr: ACCESS-phase wait counter with expiry flag.
// Only instantiated when APB_MASTER_TIMEOUT_EN is defined.
// Ports:
//   Pclk, Prst : clock, async active-low reset
//   clr        : clear the count (asserted on the cycle before ACCESS)
//   inc        : count one ACCESS cycle that saw Pready=0
//   expired    : count has reached TIMEOUT-1
module apb_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic Pclk,
  input  logic Prst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [7:0] cnt;

  assign expired = (cnt == 8'(TIMEOUT - 1));

  // Holds at the limit; the FSM leaves ACCESS on expiry anyway.
  always_ff @(posedge Pclk or negedge Prst) begin
    if (!Prst)               cnt <= '0;
    else if (clr)            cnt <= '0;
    else if (inc && !expired) cnt <= cnt + 8'd1;
  end

endmodule

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-outstanding APB master bridge.
// Accepts one read/write command on cmd_* (valid/ready), runs the APB
// SETUP and ACCESS phases, waits for Pready, and returns read data and
// error status on rsp_* (valid/ready).
// Optional macro APB_MASTER_TIMEOUT_EN: abort ACCESS after TIMEOUT cycles
// without Pready, reporting rsp_err=1.
// Ports:
//   Pclk, Prst                      : clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata: command channel
//   rsp_valid/ready/rdata/err       : response channel
//   Paddr/Pselx/Penable/Pwrite/Pwdata: APB request outputs
//   Pready/Pslverr/Prdata           : APB slave responses
module apb_cmd_master
  import apb_master_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              Pclk,
  input  logic              Prst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] Paddr,
  output logic              Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [DATA_W-1:0] Pwdata,
  input  logic              Pready,
  input  logic              Pslverr,
  input  logic [DATA_W-1:0] Prdata
);

  apb_state_t state;
  logic       tmo;

`ifdef APB_MASTER_TIMEOUT_EN
  logic tmo_hit;

  apb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .Pclk    (Pclk),
    .Prst    (Prst),
    .clr     (state == SETUP),
    .inc     (state == ACCESS && !Pready),
    .expired (tmo_hit)
  );

  // A Pready landing on the expiry cycle wins.
  assign tmo = tmo_hit && !Pready;
`else
  // No abort path: ACCESS waits for Pready indefinitely; TIMEOUT has no role.
  assign tmo = (TIMEOUT < 0);
`endif

  always_ff @(posedge Pclk or negedge Prst) begin
    if (!Prst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      Paddr     <= '0;
      Pselx     <= 1'b0;
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
      Pwdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          Paddr     <= '0;
          Pwdata    <= '0;
          if (cmd_valid && cmd_ready) begin
            state     <= SETUP;
            cmd_ready <= 1'b0;
            Pselx     <= 1'b1;
            Paddr     <= cmd_addr;
            Pwrite    <= cmd_write;
            Pwdata    <= cmd_wdata;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          Penable <= 1'b1;
        end
        ACCESS: begin
          if (Pready || tmo) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= Pready ? Pslverr : 1'b1;
            rsp_rdata <= (Pready && !Pwrite) ? Prdata : '0;
            Pselx     <= 1'b0;
            Penable   <= 1'b0;
            Pwrite    <= 1'b0;
            Paddr     <= '0;
            Pwdata    <= '0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            // Raised here so a command can be taken on the first IDLE cycle.
            cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

APB master bridge sitting directly upstream of the APB memory slave. It accepts single read/write commands on a valid/ready interface, sequences the APB SETUP and ACCESS phases, and waits for the slave's `Pready`. It then returns read data and the error status on a valid/ready response channel. It issues exactly one APB transfer per accepted command and has no outstanding-transfer pipelining.

## Interface
Parameters:
- `ADDR_W`, 5: APB address width, matching the 32-entry slave memory.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 16: maximum ACCESS cycles before forced abort. Used only with `APB_MASTER_TIMEOUT_EN`; legal range 2..255.

Ports:
- `Pclk` input 1: clock. All logic is on the rising edge.
- `Prst` input 1: reset, asynchronous, active-low; clock `Pclk`.
- `cmd_valid` input 1: a command is presented.
- `cmd_ready` output 1: the block can accept a command.
- `cmd_write` input 1: 1 = write, 0 = read.
- `cmd_addr` input ADDR_W: target address.
- `cmd_wdata` input DATA_W: write data.
- `rsp_valid` output 1: a response is available.
- `rsp_ready` input 1: the consumer accepts the response.
- `rsp_rdata` output DATA_W: read data; 0 for writes.
- `rsp_err` output 1: the slave returned `Pslverr`, or a timeout occurred.
- `Paddr` output ADDR_W: APB address.
- `Pselx` output 1: APB select.
- `Penable` output 1: APB enable.
- `Pwrite` output 1: APB direction.
- `Pwdata` output DATA_W: APB write data.
- `Pready` input 1: slave ready.
- `Pslverr` input 1: slave error.
- `Prdata` input DATA_W: slave read data.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. The encoding is 2 bits.
- IDLE:
  - `cmd_ready`=1 and all APB outputs are 0.
  - On `cmd_valid & cmd_ready`, register addr, write and wdata, then go to SETUP.
- SETUP:
  - `Pselx`=1, `Penable`=0, and `Paddr`/`Pwrite`/`Pwdata` are driven from the registered command.
  - Go unconditionally to ACCESS.
- ACCESS:
  - `Pselx`=1, `Penable`=1, and addr/data are held stable.
  - On `Pready`=1, capture `Pslverr` into `rsp_err`.
  - For a read, also capture `Prdata` into `rsp_rdata`; for a write, set `rsp_rdata`=0.
  - Then go to RESP.
  - While `Pready`=0, remain in ACCESS.
- RESP:
  - `rsp_valid`=1, `Pselx`=0, `Penable`=0.
  - Response fields are held stable until `rsp_valid & rsp_ready`, then go to IDLE.
- `cmd_ready` is 1 only in IDLE, so a new command is never accepted while a response is pending.
- Registered APB outputs are cleared to 0 on leaving ACCESS; `Pwdata` and `Paddr` are also zeroed in IDLE.
- Reset mid-operation: every output is asynchronously forced to its reset value, the FSM returns to IDLE, and the in-flight command and response are discarded without a retry.

## Timing
- Reset values: `cmd_ready`=1 (it is 0 while `Prst` is asserted, then 1 once IDLE is reached). `rsp_valid`, `rsp_err`, `rsp_rdata`, `Paddr`, `Pselx`, `Penable`, `Pwrite` and `Pwdata` are all 0.
- Command accepted at edge N gives SETUP in cycle N+1 and ACCESS from cycle N+2.
- `Pready`=1 sampled at edge N+2+k (k ≥ 0 wait states) gives `rsp_valid`=1 in cycle N+3+k.
- Minimum command-to-command interval is 4 cycles, when `rsp_ready` is already high.
- `Pready` sampled outside ACCESS is ignored.
- `cmd_*` inputs are ignored outside IDLE.

## Configuration
- `APB_MASTER_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with `Pready`=0.
  - When it reaches TIMEOUT-1 with `Pready` still 0, the FSM goes to RESP with `rsp_err`=1 and `rsp_rdata`=0.
  - `Pready` arriving in that same cycle takes priority, and the transfer completes normally.
- Undefined: ACCESS waits indefinitely, no counter logic is instantiated, and `TIMEOUT` is unused.

## Structure
- Shared package `apb_master_pkg`:
  - state encoding constants IDLE/SETUP/ACCESS/RESP;
  - default `ADDR_W`/`DATA_W` constants, shared with the slave.
- One sub-module, `apb_timeout_ctr` (counter plus expiry flag), instantiated only under `APB_MASTER_TIMEOUT_EN`.
- The FSM and datapath registers stay in the top module.

## Test plan
- Reset behaviour: assert `Prst`=0 mid-ACCESS → `Pselx`/`Penable`/`rsp_valid` are 0 immediately. After release, `cmd_ready`=1 and the first new command completes normally.
- Zero-wait write: write addr 5, data 0xDEADBEEF, slave `Pready`=1 in first ACCESS cycle →
  - SETUP in cycle 1, ACCESS in cycle 2;
  - `rsp_valid` in cycle 3 with `rsp_err`=0 and `rsp_rdata`=0.
- Read with wait states: read addr 5, `Pready` low for 3 ACCESS cycles, `Prdata`=0xDEADBEEF →
  - `Paddr`/`Penable` stable for 4 ACCESS cycles;
  - `rsp_rdata`=0xDEADBEEF.
- Slave error plus response backpressure: `Pslverr`=1 with `Pready`, `rsp_ready` held low for 5 cycles →
  - `rsp_valid`/`rsp_err`=1 held stable;
  - `cmd_ready`=0 throughout;
  - a `cmd_valid` pulse during this window is not accepted.
- Timeout (macro on, TIMEOUT=4): `Pready` never asserted → ACCESS lasts exactly 4 cycles, then `rsp_err`=1 and `rsp_rdata`=0. With the macro off, the block remains in ACCESS for more than 100 cycles.
- Back-to-back: 4 alternating write/read commands to addr 0..3 with `cmd_valid` and `rsp_ready` held high and the slave zero-wait → commands are accepted every 4 cycles and read data matches the written data.
